// File: rtl/enable_tick_gen.sv
// enable_tick_gen: NUM_CH independent programmable periodic/one-shot one-cycle enable pulses
module enable_tick_gen #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int NUM_CH = 4,
  parameter int CNT_W = 26,
  parameter int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              enable_clock,
  input  logic              enable_reset,
  input  logic              cfg_wr,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_period,
  input  logic              cfg_oneshot,
  input  logic [NUM_CH-1:0] ch_run,
  input  logic [NUM_CH-1:0] ch_clear,
  output logic [NUM_CH-1:0] pulse_out,
  output logic [NUM_CH-1:0] ch_busy,
  output logic              cfg_err
);
  logic cfg_ok;
  logic [NUM_CH-1:0] done;
  assign cfg_ok = (cfg_period != '0) && (int'(cfg_ch) < NUM_CH);
  assign ch_busy = ch_run & ~done;
  always_ff @(posedge enable_clock) cfg_err <= enable_reset ? 1'b0 : cfg_wr & ~cfg_ok;
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [CNT_W-1:0] cnt, period;
    logic oneshot, d, p, rq, wrap, active;
    assign wrap = cnt == period - 1'b1;
    assign active = ch_run[g] & (~d | ~rq);
    assign done[g] = d;
    assign pulse_out[g] = p;
    always_ff @(posedge enable_clock) begin
      rq <= enable_reset ? 1'b0 : ch_run[g];
      if (enable_reset) begin
        cnt <= '0;
        period <= CNT_W'(CLK_FREQ);
        oneshot <= 1'b0;
        d <= 1'b0;
        p <= 1'b0;
      end else if (ch_clear[g]) begin
        cnt <= '0;
        d <= 1'b0;
        p <= 1'b0;
      end else if (cfg_wr && cfg_ok && cfg_ch == CH_W'(g)) begin
        period <= cfg_period;
        oneshot <= cfg_oneshot;
        cnt <= '0;
        d <= 1'b0;
        p <= 1'b0;
      end else if (active) begin
        cnt <= wrap ? '0 : cnt + 1'b1;
        p <= wrap;
        d <= wrap & oneshot;
      end else begin
        p <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_enable_tick_gen.sv
// tb_enable_tick_gen: elapsed-cycle reference model plus directed literal checks
module tb_enable_tick_gen;
  localparam int NCH = 3;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cfg_wr = 1'b0;
  logic [1:0] cfg_ch = '0;
  logic [7:0] cfg_period = '0;
  logic cfg_oneshot = 1'b0;
  logic [NCH-1:0] ch_run = '0;
  logic [NCH-1:0] ch_clear = '0;
  logic [NCH-1:0] pulse_out, ch_busy;
  logic cfg_err;
  int checks = 0;
  int errors = 0;
  bit started = 0;
  int m_per [NCH];
  int m_el [NCH];
  bit m_os [NCH];
  bit m_fired [NCH];
  bit m_runq [NCH];
  logic [NCH-1:0] m_pulse;
  logic m_err;
  logic acc_ok;

  enable_tick_gen #(.CLK_FREQ(10), .NUM_CH(NCH), .CNT_W(8)) dut (
    .enable_clock(clk), .enable_reset(rst), .cfg_wr(cfg_wr), .cfg_ch(cfg_ch),
    .cfg_period(cfg_period), .cfg_oneshot(cfg_oneshot), .ch_run(ch_run),
    .ch_clear(ch_clear), .pulse_out(pulse_out), .ch_busy(ch_busy), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  assign acc_ok = cfg_wr && cfg_period != 0 && cfg_ch < NCH;

  // a channel pulses whenever its running-cycle count since the last arm is a multiple of its period
  always @(posedge clk) begin
    int e;
    started <= 1'b1;
    if (rst) begin
      m_err <= 1'b0;
      m_pulse <= '0;
      for (int i = 0; i < NCH; i++) begin
        m_per[i] <= 10;
        m_el[i] <= 0;
        m_os[i] <= 1'b0;
        m_fired[i] <= 1'b0;
        m_runq[i] <= 1'b0;
      end
    end else begin
      m_err <= cfg_wr && !acc_ok;
      for (int i = 0; i < NCH; i++) begin
        m_runq[i] <= ch_run[i];
        if (ch_clear[i]) begin
          m_el[i] <= 0;
          m_fired[i] <= 1'b0;
          m_pulse[i] <= 1'b0;
        end else if (acc_ok && int'(cfg_ch) == i) begin
          m_per[i] <= int'(cfg_period);
          m_os[i] <= cfg_oneshot;
          m_el[i] <= 0;
          m_fired[i] <= 1'b0;
          m_pulse[i] <= 1'b0;
        end else if (ch_run[i] && (!m_fired[i] || !m_runq[i])) begin
          e = (m_fired[i] ? 0 : m_el[i]) + 1;
          m_el[i] <= e;
          m_pulse[i] <= (e % m_per[i]) == 0;
          m_fired[i] <= m_os[i] && (e % m_per[i]) == 0;
        end else begin
          m_pulse[i] <= 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [NCH-1:0] eb;
    if (started) begin
      for (int i = 0; i < NCH; i++) eb[i] = ch_run[i] & ~m_fired[i];
      checks++;
      if ({pulse_out, ch_busy, cfg_err} !== {m_pulse, eb, m_err}) begin
        errors++;
        $display("FAIL model t=%0t pulse=%b/%b busy=%b/%b err=%b/%b (got/required)",
                 $time, pulse_out, m_pulse, ch_busy, eb, cfg_err, m_err);
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%b required=%b", name, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] ch, input logic [7:0] per, input logic os);
    cfg_wr = 1'b1;
    cfg_ch = ch;
    cfg_period = per;
    cfg_oneshot = os;
  endtask

  initial begin
    step(2);
    chk("reset_pulse", 8'(pulse_out), 8'd0);
    chk("reset_err", 8'(cfg_err), 8'd0);
    chk("reset_busy", 8'(ch_busy), 8'd0);
    rst = 1'b0;
    ch_run = 3'b111;
    step(9);
    chk("p10_c9", 8'(pulse_out), 8'd0);
    step(1);
    chk("p10_c10", 8'(pulse_out), 8'b111);
    step(1);
    chk("p10_c11", 8'(pulse_out), 8'd0);
    step(9);
    chk("p10_c20", 8'(pulse_out), 8'b111);
    wr(0, 3, 0);
    step(1);
    cfg_wr = 1'b0;
    chk("wr3_edge", 8'(pulse_out[0]), 8'd0);
    step(2);
    chk("p3_c2", 8'(pulse_out[0]), 8'd0);
    step(1);
    chk("p3_c3", 8'(pulse_out[0]), 8'd1);
    step(3);
    chk("p3_c6", 8'(pulse_out[0]), 8'd1);
    step(1);
    ch_run[0] = 1'b0;
    step(5);
    chk("pause", 8'(pulse_out[0]), 8'd0);
    ch_run[0] = 1'b1;
    step(1);
    chk("resume1", 8'(pulse_out[0]), 8'd0);
    step(1);
    chk("resume2", 8'(pulse_out[0]), 8'd1);
    wr(1, 4, 1);
    step(1);
    cfg_wr = 1'b0;
    step(3);
    chk("os_c3", 8'(pulse_out[1]), 8'd0);
    step(1);
    chk("os_c4", 8'(pulse_out[1]), 8'd1);
    chk("os_busy", 8'(ch_busy[1]), 8'd0);
    step(8);
    chk("os_idle", 8'(pulse_out[1]), 8'd0);
    ch_run[1] = 1'b0;
    step(1);
    ch_run[1] = 1'b1;
    chk("os_rearm_busy", 8'(ch_busy[1]), 8'd0);
    step(3);
    chk("os_re_c3", 8'(pulse_out[1]), 8'd0);
    step(1);
    chk("os_re_c4", 8'(pulse_out[1]), 8'd1);
    wr(0, 0, 0);
    step(1);
    cfg_wr = 1'b0;
    chk("rej_p0", 8'(cfg_err), 8'd1);
    step(1);
    chk("rej_p0_clr", 8'(cfg_err), 8'd0);
    wr(3, 5, 0);
    step(1);
    cfg_wr = 1'b0;
    chk("rej_ch3", 8'(cfg_err), 8'd1);
    step(1);
    wr(0, 5, 0);
    ch_clear[0] = 1'b1;
    step(1);
    cfg_wr = 1'b0;
    ch_clear[0] = 1'b0;
    chk("clr_err", 8'(cfg_err), 8'd0);
    chk("clr_pulse", 8'(pulse_out[0]), 8'd0);
    step(2);
    chk("clr_c2", 8'(pulse_out[0]), 8'd0);
    step(1);
    chk("clr_c3_oldper", 8'(pulse_out[0]), 8'd1);
    wr(0, 1, 0);
    step(1);
    cfg_wr = 1'b0;
    step(1);
    chk("p1_a", 8'(pulse_out[0]), 8'd1);
    step(1);
    chk("p1_b", 8'(pulse_out[0]), 8'd1);
    wr(0, 20, 0);
    step(1);
    cfg_wr = 1'b0;
    step(7);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("mid_rst", 8'(pulse_out), 8'd0);
    step(9);
    chk("post_rst_c9", 8'(pulse_out), 8'd0);
    step(1);
    chk("post_rst_c10", 8'(pulse_out), 8'b111);
    step(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
